// File: rtl/dm_access_unit.sv
`default_nettype none
// dm_access_unit: RV32I load/store adapter for the DM1 16384x32 SRAM (active-low controls, 1-cycle read).
// Optional feature macro DM_MISALIGN_SPLIT_EN: split misaligned accesses into two word accesses.
module dm_access_unit #(
  parameter int unsigned   AW           = 14,
  parameter logic [AW-1:0] SIM_END_WORD = 14'h3fff,
  parameter logic [31:0]   SIM_END_CODE = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [4:0]    req_rd,
  output logic          busy,
  output logic          ld_valid,
  output logic [31:0]   ld_data,
  output logic [4:0]    ld_rd,
  output logic          acc_err,
  output logic          sim_end,
  output logic          sram_ceb,
  output logic          sram_web,
  output logic [31:0]   sram_bweb,
  output logic [AW-1:0] sram_a,
  output logic [31:0]   sram_d,
  input  logic [31:0]   sram_q
);

  function automatic logic [31:0] lanes_to_bits(input logic [3:0] lanes_in);
    logic [31:0] bits;
    for (int i = 0; i < 4; i++) bits[8*i +: 8] = {8{lanes_in[i]}};
    return bits;
  endfunction

  logic [1:0]    off;
  logic [4:0]    st_sh;
  logic [AW-1:0] word;
  logic [7:0]    lanes;  // bits [7:4] are lanes that spill into the next word
  logic [31:0]   wdata_rep;
  logic          f3_legal, misal, accept, err, go;
  logic          unused_bits;

  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic [4:0]    rd_q;
  logic          ld_pend_q, ld_pend_d;
  logic          acc_err_q, acc_err_d;
  logic          sim_end_q, sim_end_d;
  logic [4:0]    ld_sh;
  logic [31:0]   ld_word, ld_ext;

  assign off   = req_addr[1:0];
  assign st_sh = {off, 3'b000};
  assign word  = req_addr[AW+1:2];
  assign ld_sh = {off_q, 3'b000};

  always_comb begin
    if (req_we) f3_legal = (req_funct3 <= 3'd2);
    else        f3_legal = (req_funct3 != 3'd3) && (req_funct3 != 3'd6) && (req_funct3 != 3'd7);
    case (req_funct3[1:0])
      2'd1:    misal = off[0];
      2'd2:    misal = (off != 2'd0);
      default: misal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'd0: begin
        lanes     = 8'b0000_0001 << off;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lanes     = 8'b0000_0011 << off;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        lanes     = 8'b0000_1111 << off;
        wdata_rep = req_wdata;
      end
    endcase
  end

`ifdef DM_MISALIGN_SPLIT_EN
  typedef enum logic [0:0] {IDLE = 1'b0, SPLIT_HI = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          split_q, split_d;
  logic [31:0]   lo_q, lo_d;
  logic [AW-1:0] a_hi_q, a_hi_d;
  logic [31:0]   d_hi_q, d_hi_d;
  logic [31:0]   bweb_hi_q, bweb_hi_d;
  logic          we_hi_q, we_hi_d;
  logic [31:0]   wdata_rot;

  // Byte i of the store lands in lane (off+i) mod 4, spanning W and W+1.
  assign wdata_rot   = (req_wdata << st_sh) | (req_wdata >> (6'd32 - {1'b0, st_sh}));
  assign busy        = (state_q == SPLIT_HI);
  assign err         = !f3_legal;
  assign unused_bits = ^req_addr[31:AW+2];
  assign ld_word     = split_q ? ((lo_q >> ld_sh) | (sram_q << (6'd32 - {1'b0, ld_sh})))
                               : (sram_q >> ld_sh);
`else
  assign busy        = 1'b0;
  assign err         = !f3_legal || misal;
  assign unused_bits = ^{req_addr[31:AW+2], lanes[7:4], st_sh};
  assign ld_word     = sram_q >> ld_sh;
`endif

  assign accept = req_valid && !busy && !rst;
  assign go     = accept && !err;

  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = '1;
    sram_a    = '0;
    sram_d    = '0;
    ld_pend_d = 1'b0;
    acc_err_d = accept && err;
    sim_end_d = sim_end_q || (go && req_we && (req_funct3 == 3'd2) && !misal &&
                              (word == SIM_END_WORD) && (req_wdata == SIM_END_CODE));
`ifdef DM_MISALIGN_SPLIT_EN
    state_d   = state_q;
    split_d   = 1'b0;
    lo_d      = lo_q;
    a_hi_d    = a_hi_q;
    d_hi_d    = d_hi_q;
    bweb_hi_d = bweb_hi_q;
    we_hi_d   = we_hi_q;
    if (state_q == SPLIT_HI) begin
      sram_ceb  = 1'b0;
      sram_web  = !we_hi_q;
      sram_a    = a_hi_q;
      sram_d    = d_hi_q;
      if (we_hi_q) sram_bweb = bweb_hi_q;
      ld_pend_d = !we_hi_q;
      split_d   = !we_hi_q;
      lo_d      = sram_q;  // low word read in the previous cycle
      state_d   = IDLE;
    end else if (go) begin
      sram_ceb = 1'b0;
      sram_web = !req_we;
      sram_a   = word;
      if (misal) begin
        if (req_we) begin
          sram_bweb = ~lanes_to_bits(lanes[3:0]);
          sram_d    = wdata_rot;
        end
        a_hi_d    = word + AW'(1);
        d_hi_d    = wdata_rot;
        bweb_hi_d = ~lanes_to_bits(lanes[7:4]);
        we_hi_d   = req_we;
        state_d   = SPLIT_HI;
      end else begin
        if (req_we) begin
          sram_bweb = ~lanes_to_bits(lanes[3:0]);
          sram_d    = wdata_rep;
        end
        ld_pend_d = !req_we;
      end
    end
`else
    if (go) begin
      sram_ceb = 1'b0;
      sram_web = !req_we;
      sram_a   = word;
      if (req_we) begin
        sram_bweb = ~lanes_to_bits(lanes[3:0]);
        sram_d    = wdata_rep;
      end
      ld_pend_d = !req_we;
    end
`endif
  end

  always_comb begin
    case (f3_q)
      3'd0:    ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'd1:    ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'd4:    ld_ext = {24'd0, ld_word[7:0]};
      3'd5:    ld_ext = {16'd0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  assign ld_valid = ld_pend_q;
  assign ld_data  = ld_pend_q ? ld_ext : 32'd0;
  assign ld_rd    = rd_q;
  assign acc_err  = acc_err_q;
  assign sim_end  = sim_end_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      ld_pend_q <= 1'b0;
      acc_err_q <= 1'b0;
      sim_end_q <= 1'b0;
`ifdef DM_MISALIGN_SPLIT_EN
      state_q   <= IDLE;
      split_q   <= 1'b0;
      lo_q      <= '0;
      a_hi_q    <= '0;
      d_hi_q    <= '0;
      bweb_hi_q <= '1;
      we_hi_q   <= 1'b0;
`endif
    end else begin
      ld_pend_q <= ld_pend_d;
      acc_err_q <= acc_err_d;
      sim_end_q <= sim_end_d;
      if (accept) begin
        off_q <= off;
        f3_q  <= req_funct3;
        rd_q  <= req_rd;
      end
`ifdef DM_MISALIGN_SPLIT_EN
      state_q   <= state_d;
      split_q   <= split_d;
      lo_q      <= lo_d;
      a_hi_q    <= a_hi_d;
      d_hi_q    <= d_hi_d;
      bweb_hi_q <= bweb_hi_d;
      we_hi_q   <= we_hi_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_access_unit.sv
`default_nettype none
// tb_dm_access_unit: randomized bench for dm_access_unit against a byte-addressed reference memory.
module tb_dm_access_unit;
  localparam int AW = 14;
`ifdef DM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic [4:0]    req_rd;
  logic          busy, ld_valid, acc_err, sim_end;
  logic [31:0]   ld_data;
  logic [4:0]    ld_rd;
  logic          sram_ceb, sram_web;
  logic [31:0]   sram_bweb, sram_d, sram_q;
  logic [AW-1:0] sram_a;

  always #5 clk = ~clk;

  dm_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .busy(busy), .ld_valid(ld_valid), .ld_data(ld_data), .ld_rd(ld_rd),
    .acc_err(acc_err), .sim_end(sim_end),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  // The SRAM macro the unit drives
  logic [31:0] sram_mem [0:16383];
  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_bweb) | (sram_d & ~sram_bweb);
      sram_q <= sram_mem[sram_a];
    end
  end

  logic [7:0] ref_mem [0:65535];
  bit         ref_sim_end;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [15:0] a);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < size_of(f3); i++) v[8*i +: 8] = ref_mem[(int'(a) + i) % 65536];
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Expected write mask and written bytes for word part 0 (W) or 1 (W+1).
  function automatic void exp_store(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] wd,
                                    input int part, output logic [31:0] bw, output logic [31:0] dd);
    bw = '1;
    dd = '0;
    for (int i = 0; i < size_of(f3); i++) begin
      int lane;
      lane = int'(off) + i - 4*part;
      if (lane >= 0 && lane < 4) begin
        bw[8*lane +: 8] = 8'h00;
        dd[8*lane +: 8] = wd[8*i +: 8];
      end
    end
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd,
                       output logic [31:0] ld_o, output logic [31:0] bweb_o);
    int          n;
    bit          legal, misal, split, err;
    logic [13:0] w0, w1;
    logic [31:0] bw, dd, exp_ld;
    n      = size_of(f3);
    legal  = is_legal(we, f3);
    misal  = (int'(addr[1:0]) % n) != 0;
    split  = legal && misal && SPLIT;
    err    = !legal || (misal && !SPLIT);
    w0     = addr[15:2];
    w1     = w0 + 14'd1;
    exp_ld = '0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    #1;
    check("ceb", 32'(sram_ceb), 32'(err));
    if (!err) begin
      check("web", 32'(sram_web), 32'(!we));
      check("addr", 32'(sram_a), 32'(w0));
      if (we) begin
        exp_store(f3, addr[1:0], wd, 0, bw, dd);
        check("bweb", sram_bweb, bw);
        check("wdata", sram_d & ~bw, dd);
      end
    end
    bweb_o = sram_bweb;
    if (!err && we) begin
      for (int i = 0; i < n; i++) ref_mem[(int'(addr[15:0]) + i) % 65536] = wd[8*i +: 8];
      if (f3 == 3'd2 && !misal && w0 == 14'h3fff && wd == 32'hFFFF_FFFF) ref_sim_end = 1'b1;
    end
    if (!err && !we) exp_ld = ref_load(f3, addr[15:0]);
    @(negedge clk);
    if (split) begin
      check("split_busy", 32'(busy), 32'd1);
      check("split_ceb", 32'(sram_ceb), 32'd0);
      check("split_web", 32'(sram_web), 32'(!we));
      check("split_addr", 32'(sram_a), 32'(w1));
      if (we) begin
        exp_store(f3, addr[1:0], wd, 1, bw, dd);
        check("split_bweb", sram_bweb, bw);
        check("split_wdata", sram_d & ~bw, dd);
      end
      check("split_early_ldv", 32'(ld_valid), 32'd0);
      check("split_err", 32'(acc_err), 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
    end else begin
      check("busy", 32'(busy), 32'd0);
    end
    check("acc_err", 32'(acc_err), 32'(err));
    check("ld_valid", 32'(ld_valid), 32'(!err && !we));
    if (!err && !we) begin
      check("ld_data", ld_data, exp_ld);
      check("ld_rd", 32'(ld_rd), 32'(rd));
    end
    check("sim_end", 32'(sim_end), 32'(ref_sim_end));
    ld_o = ld_data;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_ceb", 32'(sram_ceb), 32'd1);
    check("rst_web", 32'(sram_web), 32'd1);
    check("rst_bweb", sram_bweb, 32'hFFFF_FFFF);
    check("rst_a", 32'(sram_a), 32'd0);
    check("rst_d", sram_d, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ldv", 32'(ld_valid), 32'd0);
    check("rst_ldd", ld_data, 32'd0);
    check("rst_ldrd", 32'(ld_rd), 32'd0);
    check("rst_err", 32'(acc_err), 32'd0);
    check("rst_simend", 32'(sim_end), 32'd0);
  endtask

  initial begin
    logic [31:0] ld, bw, r, wd, addr, v;
    logic [15:0] lo;
    logic [2:0]  f3;
    logic        we;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    ref_sim_end = 1'b0;
    for (int w = 0; w < 16384; w++) begin
      v = $urandom;
      sram_mem[w] = v;
      for (int i = 0; i < 4; i++) ref_mem[4*w + i] = v[8*i +: 8];
    end
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    issue(1'b1, 3'd2, 32'h0000_8000, 32'h1234_5678, 5'd0, ld, bw);
    check("sw_bweb", bw, 32'h0000_0000);
    issue(1'b0, 3'd2, 32'h0000_8000, 32'h0, 5'd7, ld, bw);
    check("lw_data", ld, 32'h1234_5678);
    issue(1'b1, 3'd0, 32'h0000_8003, 32'h0000_00AB, 5'd0, ld, bw);
    check("sb_bweb", bw, 32'h00FF_FFFF);
    issue(1'b0, 3'd0, 32'h0000_8003, 32'h0, 5'd3, ld, bw);
    check("lb_data", ld, 32'hFFFF_FFAB);
    issue(1'b0, 3'd4, 32'h0000_8003, 32'h0, 5'd4, ld, bw);
    check("lbu_data", ld, 32'h0000_00AB);
    issue(1'b1, 3'd1, 32'h0000_8002, 32'h0000_80F0, 5'd0, ld, bw);
    issue(1'b0, 3'd1, 32'h0000_8002, 32'h0, 5'd5, ld, bw);
    check("lh_data", ld, 32'hFFFF_80F0);
    idle();
    issue(1'b0, 3'd2, 32'h0000_8001, 32'h0, 5'd6, ld, bw);
    issue(1'b0, 3'd3, 32'h0000_8000, 32'h0, 5'd6, ld, bw);
    idle();
    issue(1'b1, 3'd2, 32'h0000_FFFC, 32'hFFFF_FFFE, 5'd0, ld, bw);
    check("simend_neg", 32'(sim_end), 32'd0);
    issue(1'b1, 3'd2, 32'h0000_FFFC, 32'hFFFF_FFFF, 5'd0, ld, bw);
    idle();
    idle();
    check("simend_sticky", 32'(sim_end), 32'd1);

    issue(1'b1, 3'd2, 32'h0000_8000, 32'h4433_2211, 5'd0, ld, bw);
    issue(1'b1, 3'd2, 32'h0000_8004, 32'h8877_6655, 5'd0, ld, bw);
    issue(1'b0, 3'd2, 32'h0000_8002, 32'h0, 5'd9, ld, bw);
`ifdef DM_MISALIGN_SPLIT_EN
    check("split_lw", ld, 32'h6655_4433);
`endif
    issue(1'b0, 3'd2, 32'h0000_FFFE, 32'h0, 5'd10, ld, bw);
    idle();

    // Reset lands in the cycle after a load is accepted
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_8002; req_rd = 5'd17;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_vals();
    ref_sim_end = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ldv", 32'(ld_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("post_rst_ldv2", 32'(ld_valid), 32'd0);

    for (int k = 0; k < 400; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      r  = $urandom;
      lo = ($urandom_range(0, 9) < 8) ? 16'h8000 + 16'($urandom_range(0, 31))
                                      : 16'hFFF8 + 16'($urandom_range(0, 7));
      addr = {r[31:16], lo};
      wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      issue(we, f3, addr, wd, 5'($urandom_range(0, 31)), ld, bw);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
